// File: rtl/clock_display_pkg.sv
// Shared constants and types for the four-digit time-of-day display driver.
package clock_display_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        DISP_HHMM = 1'b0,
        DISP_MMSS = 1'b1
    } disp_mode_t;

    // Decimal tens of a 6-bit value (0..6 for any input)
    function automatic logic [3:0] dec_tens(input logic [5:0] value);
        return 4'(value / 6'd10);
    endfunction

    // Decimal ones of a 6-bit value
    function automatic logic [3:0] dec_ones(input logic [5:0] value);
        return 4'(value % 6'd10);
    endfunction

endpackage

// File: rtl/clock_display_mux_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with dash and blank overrides.
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over dash; non-decimal codes fall back to a dash so the pins never see junk
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (!dash) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/clock_display_mux.sv
// Time-multiplexed four-digit 7-segment driver for the time-of-day counter.
// Shows HH:MM or MM:SS from a per-frame snapshot, with a colon on digit 2.
module clock_display_mux
    import clock_display_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter bit BLANK_HOUR_TENS = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] second,
    input  logic [5:0] minute,
    input  logic [4:0] hour,
    input  logic       mode,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] refresh_cnt;
    logic             tick;
    // scan_idx is the digit that the next tick puts on the pins
    digit_idx_t       scan_idx;
    logic             frame_start;

    logic [5:0]       snap_second;
    logic [5:0]       snap_minute;
    logic [4:0]       snap_hour;
    disp_mode_t       snap_mode;

    logic [5:0]       cur_second;
    logic [5:0]       cur_minute;
    logic [4:0]       cur_hour;
    disp_mode_t       cur_mode;

    logic [5:0]       left_val;
    logic [5:0]       right_val;
    logic             left_bad;
    logic             right_bad;
    logic [3:0]       digit_val;
    logic             digit_dash;
    logic             digit_blank;
    logic             colon_on;
    logic [6:0]       seg_next;

    assign tick        = (refresh_cnt == CNT_LAST);
    // Digit 0 of every frame, including the very first tick after reset, takes a new sample
    assign frame_start = tick && (scan_idx == digit_idx_t'(0));

    // Refresh counter: free-running 0..REFRESH_DIV-1, wrap produces the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Scan index advances one digit per tick, wrapping 3 -> 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx <= '0;
        end else if (tick) begin
            scan_idx <= scan_idx + 1'b1;
        end
    end

    // Snapshot of the time fields and mode, refreshed only at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_second <= '0;
            snap_minute <= '0;
            snap_hour   <= '0;
            snap_mode   <= DISP_HHMM;
        end else if (frame_start) begin
            snap_second <= second;
            snap_minute <= minute;
            snap_hour   <= hour;
            snap_mode   <= disp_mode_t'(mode);
        end
    end

    // Digit 0 is rendered from the sample being captured on the same edge
    always_comb begin
        cur_second = frame_start ? second : snap_second;
        cur_minute = frame_start ? minute : snap_minute;
        cur_hour   = frame_start ? hour   : snap_hour;
        cur_mode   = frame_start ? disp_mode_t'(mode) : snap_mode;
    end

    // Field selection, range check and per-digit decimal split
    always_comb begin
        left_val    = (cur_mode == DISP_MMSS) ? cur_minute : {1'b0, cur_hour};
        right_val   = (cur_mode == DISP_MMSS) ? cur_second : cur_minute;
        left_bad    = (cur_mode == DISP_MMSS) ? (cur_minute >= 6'd60) : (cur_hour >= 5'd24);
        right_bad   = (right_val >= 6'd60);
        digit_val   = 4'd0;
        case (scan_idx)
            2'd0:    digit_val = dec_ones(right_val);
            2'd1:    digit_val = dec_tens(right_val);
            2'd2:    digit_val = dec_ones(left_val);
            default: digit_val = dec_tens(left_val);
        endcase
        digit_dash  = scan_idx[1] ? left_bad : right_bad;
        digit_blank = BLANK_HOUR_TENS && (cur_mode == DISP_HHMM) &&
                      (scan_idx == digit_idx_t'(3)) && (cur_hour < 5'd10);
        colon_on    = (scan_idx == digit_idx_t'(2)) &&
                      ((cur_mode == DISP_MMSS) || !cur_second[0]);
    end

    seg7_decode u_seg7_decode (
        .digit (digit_val),
        .dash  (digit_dash),
        .blank (digit_blank),
        .seg   (seg_next)
    );

    // Output registers: anode, segments and colon switch together on the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= ~(4'b0001 << scan_idx);
            seg <= seg_next;
            dp  <= ~colon_on;
        end
    end

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux with a cycle-level reference model.
module tb_clock_display_mux;

    localparam int D = 4;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    clock_display_mux #(
        .REFRESH_DIV     (D),
        .BLANK_HOUR_TENS (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .second  (second),
        .minute  (minute),
        .hour    (hour),
        .mode    (mode),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // What digit d of a frame looks like for a given sample
    function automatic void model_digit(input int d, input int h, input int m, input int s,
                                        input int md, output logic [6:0] sg, output logic dpv);
        int left, right, val;
        bit bad;
        left  = md ? m : h;
        right = md ? s : m;
        case (d)
            0: val = right % 10;
            1: val = right / 10;
            2: val = left % 10;
            default: val = left / 10;
        endcase
        bad = (d >= 2) ? (md ? (m >= 60) : (h >= 24)) : (right >= 60);
        if (bad) sg = S_DASH;
        else if (d == 3 && md == 0 && h < 10) sg = S_BLANK;
        else sg = seg_of(val);
        dpv = !(d == 2 && (md == 1 || (s % 2) == 0));
    endfunction

    // Reference model: counts edges since reset release and derives tick/digit/frame arithmetically
    int m_edges;
    int sn_h, sn_m, sn_s, sn_md;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    always @(posedge clk or negedge reset_n) begin : model
        int k, d, h, mi, s, md;
        logic [6:0] sg;
        logic dpv;
        if (!reset_n) begin
            m_edges <= 0;
            sn_h <= 0; sn_m <= 0; sn_s <= 0; sn_md <= 0;
            m_an <= 4'b1111; m_seg <= S_BLANK; m_dp <= 1'b1;
        end else begin
            k = m_edges + 1;
            m_edges <= k;
            if (k % D == 0) begin
                d = ((k / D) - 1) % 4;
                if (d == 0) begin
                    h = int'(hour); mi = int'(minute); s = int'(second); md = int'(mode);
                end else begin
                    h = sn_h; mi = sn_m; s = sn_s; md = sn_md;
                end
                sn_h <= h; sn_m <= mi; sn_s <= s; sn_md <= md;
                model_digit(d, h, mi, s, md, sg, dpv);
                m_an  <= ~(4'b0001 << d);
                m_seg <= sg;
                m_dp  <= dpv;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", 32'(an), 32'(m_an));
            check("model_seg", 32'(seg), 32'(m_seg));
            check("model_dp", 32'(dp), 32'(m_dp));
        end
    end

    // Wait (bounded) for digit idx to be lit, then check its pattern against a constant
    task automatic show(input string tag, input int idx, input logic [6:0] exp_seg, input logic exp_dp);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << idx);
        n = 0;
        while (an !== want && n < 6 * D) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_an"}, 32'(an), 32'(want));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
        check({tag, "_dp"}, 32'(dp), 32'(exp_dp));
    endtask

    task automatic set_in(input int h, input int m, input int s, input int md);
        hour = 5'(h); minute = 6'(m); second = 6'(s); mode = md[0];
    endtask

    task automatic release_and_check_start(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check({tag, "_pre_an"}, 32'(an), 32'hf);
        end
        @(negedge clk);
        check({tag, "_first_an"}, 32'(an), 32'he);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(13, 7, 42, 0);
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_dp", 32'(dp), 32'h1);
        chk_en = 1'b1;

        // 13:07, second even
        release_and_check_start("start");
        show("hhmm_d0", 0, seg_of(7), 1'b1);
        show("hhmm_d1", 1, seg_of(0), 1'b1);
        show("hhmm_d2", 2, seg_of(3), 1'b0);
        show("hhmm_d3", 3, seg_of(1), 1'b1);

        // 5:59, second odd: hour tens blanked, colon off
        set_in(5, 59, 1, 0);
        show("blank_d0", 0, seg_of(9), 1'b1);
        show("blank_d1", 1, seg_of(5), 1'b1);
        show("blank_d2", 2, seg_of(5), 1'b1);
        show("blank_d3", 3, S_BLANK, 1'b1);

        // MM:SS 30:59, colon always on
        set_in(5, 30, 59, 1);
        show("mmss_d0", 0, seg_of(9), 1'b1);
        show("mmss_d1", 1, seg_of(5), 1'b1);
        show("mmss_d2", 2, seg_of(0), 1'b0);
        show("mmss_d3", 3, seg_of(3), 1'b1);
        show("mmss_d2b", 2, seg_of(0), 1'b0);

        // Out of range in both pairs
        @(negedge clk);
        set_in(24, 61, 59, 0);
        show("range_d3w", 3, seg_of(3), 1'b1);
        show("range_d0", 0, S_DASH, 1'b1);
        show("range_d1", 1, S_DASH, 1'b1);
        show("range_d2", 2, S_DASH, 1'b1);
        show("range_d3", 3, S_DASH, 1'b1);

        // Minute changes during digit 1: old value holds for this frame
        set_in(13, 7, 42, 0);
        show("tear_d0", 0, seg_of(7), 1'b1);
        show("tear_d1", 1, seg_of(0), 1'b1);
        set_in(13, 48, 42, 0);
        show("tear_d2", 2, seg_of(3), 1'b0);
        show("tear_d3", 3, seg_of(1), 1'b1);
        show("tear_n0", 0, seg_of(8), 1'b1);
        show("tear_n1", 1, seg_of(4), 1'b1);

        // Asynchronous reset mid-frame blanks immediately
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hf);
        check("async_seg", 32'(seg), 32'h7f);
        check("async_dp", 32'(dp), 32'h1);
        release_and_check_start("restart");

        // Randomized inputs with occasional out-of-range values and reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0)
                    set_in($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                           $urandom_range(0, 1));
                else
                    set_in($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                           $urandom_range(0, 1));
            end
            if ($urandom_range(0, 599) == 0) begin
                #1 reset_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
